// File: rtl/elevator_motion_ctrl.sv
// SCAN motion controller for a 4-floor car: latches calls, times moves and door dwell,
// and writes each new floor back to the external one-hot location register.
module elevator_motion_ctrl #(
    parameter int TRAVEL_CYCLES = 8,
    parameter int DOOR_CYCLES   = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] loc_q,
    input  logic [3:0] call_req,
    output logic [3:0] loc_p,
    output logic       loc_s,
    output logic       motor_up,
    output logic       motor_dn,
    output logic       door_open,
    output logic [3:0] pending,
    output logic       fault
);

    localparam int MAX_CYCLES = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int TW = (MAX_CYCLES < 2) ? 1 : $clog2(MAX_CYCLES + 1);
    localparam logic [TW-1:0] TRAVEL_LAST = TW'(TRAVEL_CYCLES - 1);
    localparam logic [TW-1:0] DOOR_LAST   = TW'(DOOR_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        MOVE,
        STEP,
        SETTLE,
        DOOR
    } state_t;

    state_t        state_q, state_d;
    logic          dir_up_q, dir_up_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [3:0]    pending_q, pending_d;

    logic       loc_onehot;
    logic [3:0] below_mask;
    logic [3:0] above_mask;
    logic [3:0] above;
    logic [3:0] below;
    logic [3:0] clear_mask;
    logic       here;
    logic       ahead;

    // Masks are only meaningful for a one-hot location; fault blocks every decision otherwise.
    always_comb begin
        loc_onehot = (loc_q != 4'b0000) && ((loc_q & (loc_q - 4'd1)) == 4'b0000);
        below_mask = loc_q - 4'd1;
        above_mask = ~(below_mask | loc_q);
        above      = pending_q & above_mask;
        below      = pending_q & below_mask;
        here       = |(pending_q & loc_q);
        ahead      = dir_up_q ? (|above) : (|below);
    end

    always_comb begin
        state_d    = state_q;
        dir_up_d   = dir_up_q;
        timer_d    = timer_q;
        clear_mask = 4'b0000;
        if (!loc_onehot) begin
            state_d = IDLE;
            timer_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (here) begin
                        state_d    = DOOR;
                        timer_d    = '0;
                        clear_mask = loc_q;
                    end else if ((|above) && (dir_up_q || (below == 4'b0000))) begin
                        dir_up_d = 1'b1;
                        state_d  = MOVE;
                        timer_d  = '0;
                    end else if (|below) begin
                        dir_up_d = 1'b0;
                        state_d  = MOVE;
                        timer_d  = '0;
                    end
                end
                MOVE: begin
                    if (timer_q == TRAVEL_LAST) begin
                        state_d = STEP;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                STEP: begin
                    state_d = SETTLE;
                end
                SETTLE: begin
                    if (here) begin
                        state_d    = DOOR;
                        timer_d    = '0;
                        clear_mask = loc_q;
                    end else if (ahead) begin
                        state_d = MOVE;
                        timer_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
                DOOR: begin
                    // A re-press at this floor is absorbed and restarts the dwell.
                    clear_mask = loc_q;
                    if (|(call_req & loc_q)) begin
                        timer_d = '0;
                    end else if (timer_q == DOOR_LAST) begin
                        state_d = IDLE;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    timer_d = '0;
                end
            endcase
        end
        pending_d = (pending_q | call_req) & ~clear_mask;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            dir_up_q  <= 1'b1;
            timer_q   <= '0;
            pending_q <= 4'b0000;
        end else begin
            state_q   <= state_d;
            dir_up_q  <= dir_up_d;
            timer_q   <= timer_d;
            pending_q <= pending_d;
        end
    end

    // loc_p mirrors loc_q outside STEP so an unexpected load rewrites the same floor.
    always_comb begin
        loc_p     = loc_q;
        loc_s     = 1'b0;
        motor_up  = 1'b0;
        motor_dn  = 1'b0;
        door_open = 1'b0;
        if (reset && loc_onehot) begin
            case (state_q)
                MOVE: begin
                    motor_up = dir_up_q;
                    motor_dn = ~dir_up_q;
                end
                STEP: begin
                    loc_s = 1'b1;
                    loc_p = dir_up_q ? (loc_q << 1) : (loc_q >> 1);
                end
                DOOR: begin
                    door_open = 1'b1;
                end
                default: begin
                end
            endcase
        end
        if (!reset) begin
            loc_p = 4'b0000;
        end
        pending = pending_q;
        fault   = reset & ~loc_onehot;
    end

endmodule

// File: tb/tb_elevator_motion_ctrl.sv
// Bench for elevator_motion_ctrl: directed scenarios plus random calls and location faults,
// compared every cycle against a countdown-based scheduler model with an external location register.
module tb_elevator_motion_ctrl;

    localparam int TRAVEL = 8;
    localparam int DOOR   = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] loc_q = 4'b0001;
    logic [3:0] call_req = 4'b0000;
    logic [3:0] loc_p;
    logic       loc_s;
    logic       motor_up;
    logic       motor_dn;
    logic       door_open;
    logic [3:0] pending;
    logic       fault;

    elevator_motion_ctrl #(
        .TRAVEL_CYCLES(TRAVEL),
        .DOOR_CYCLES  (DOOR)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .loc_q    (loc_q),
        .call_req (call_req),
        .loc_p    (loc_p),
        .loc_s    (loc_s),
        .motor_up (motor_up),
        .motor_dn (motor_dn),
        .door_open(door_open),
        .pending  (pending),
        .fault    (fault)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    logic [3:0] loc_reg = 4'b0001;
    bit         force_en = 1'b0;
    logic [3:0] force_val = 4'b0000;

    int       m_move_left;
    int       m_door_left;
    int       m_dir;
    bit       m_step;
    bit       m_settle;
    bit [3:0] m_pend;

    int         stops[$];
    logic [3:0] strobes[$];
    bit         prev_door = 1'b0;
    bit         last_door = 1'b0;
    bit         loc_s_seen = 1'b0;
    bit         mu_seen = 1'b0;
    int         door_cnt;

    function automatic bit is_onehot(input logic [3:0] v);
        return $countones(v) == 1;
    endfunction

    function automatic int floor_of(input logic [3:0] v);
        for (int i = 0; i < 4; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_move_left = 0;
        m_door_left = 0;
        m_dir       = 1;
        m_step      = 1'b0;
        m_settle    = 1'b0;
        m_pend      = 4'b0000;
    endtask

    // Scheduler rules applied at one clock edge, using the calls latched before that edge.
    task automatic model_edge(input logic [3:0] call, input logic [3:0] lq);
        bit [3:0] np;
        int fl;
        bit above;
        bit below;
        bit ahead;
        np = m_pend | call;
        if (!is_onehot(lq)) begin
            m_move_left = 0;
            m_door_left = 0;
            m_step      = 1'b0;
            m_settle    = 1'b0;
            m_pend      = np;
            return;
        end
        fl    = floor_of(lq);
        above = 1'b0;
        below = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (m_pend[i] && i > fl) above = 1'b1;
            if (m_pend[i] && i < fl) below = 1'b1;
        end
        ahead = (m_dir > 0) ? above : below;
        if (m_move_left > 0) begin
            m_move_left--;
            if (m_move_left == 0) m_step = 1'b1;
        end else if (m_step) begin
            m_step   = 1'b0;
            m_settle = 1'b1;
        end else if (m_settle) begin
            m_settle = 1'b0;
            if (m_pend[fl]) begin
                m_door_left = DOOR;
                np[fl]      = 1'b0;
            end else if (ahead) begin
                m_move_left = TRAVEL;
            end
        end else if (m_door_left > 0) begin
            np[fl] = 1'b0;
            if (call[fl]) m_door_left = DOOR;
            else m_door_left--;
        end else if (m_pend[fl]) begin
            m_door_left = DOOR;
            np[fl]      = 1'b0;
        end else if (above && (m_dir > 0 || !below)) begin
            m_dir       = 1;
            m_move_left = TRAVEL;
        end else if (below) begin
            m_dir       = -1;
            m_move_left = TRAVEL;
        end
        m_pend = np;
    endtask

    task automatic check_output(input logic [3:0] lq);
        bit         f;
        logic [3:0] exp_p;
        f     = !is_onehot(lq);
        exp_p = lq;
        if (!f && m_step) exp_p = (m_dir > 0) ? (lq << 1) : (lq >> 1);
        chk("fault", int'(fault), int'(f));
        chk("motor_up", int'(motor_up), int'(!f && m_move_left > 0 && m_dir > 0));
        chk("motor_dn", int'(motor_dn), int'(!f && m_move_left > 0 && m_dir < 0));
        chk("loc_s", int'(loc_s), int'(!f && m_step));
        chk("loc_p", int'(loc_p), int'(exp_p));
        chk("door_open", int'(door_open), int'(!f && m_door_left > 0));
        chk("pending", int'(pending), int'(m_pend));
    endtask

    // One clock cycle: drive at the falling edge, check, then advance model and location register.
    task automatic apply_stimulus(input logic [3:0] call);
        logic [3:0] lp;
        logic       ls;
        @(negedge clk);
        call_req = call;
        loc_q    = force_en ? force_val : loc_reg;
        #1;
        check_output(loc_q);
        if (door_open && !prev_door) stops.push_back(floor_of(loc_q));
        prev_door = door_open;
        last_door = door_open;
        if (loc_s) begin
            loc_s_seen = 1'b1;
            strobes.push_back(loc_p);
        end
        if (motor_up) mu_seen = 1'b1;
        lp = loc_p;
        ls = loc_s;
        @(posedge clk);
        model_edge(call, loc_q);
        if (ls) loc_reg = lp;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        reset    = 1'b0;
        call_req = 4'b0000;
        #1;
        chk("rst_motor_up", int'(motor_up), 0);
        chk("rst_motor_dn", int'(motor_dn), 0);
        chk("rst_loc_s", int'(loc_s), 0);
        chk("rst_loc_p", int'(loc_p), 0);
        chk("rst_door", int'(door_open), 0);
        chk("rst_pending", int'(pending), 0);
        chk("rst_fault", int'(fault), 0);
        model_reset();
        repeat (2) @(negedge clk);
        reset     = 1'b1;
        prev_door = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        apply_stimulus(4'b0000);

        $display("[TB] reset during an upward move");
        loc_reg = 4'b0001;
        apply_stimulus(4'b0100);
        repeat (4) apply_stimulus(4'b0000);
        chk("t1_moving", int'(motor_up), 1);
        loc_s_seen = 1'b0;
        do_reset();
        repeat (20) apply_stimulus(4'b0000);
        chk("t1_no_strobe", int'(loc_s_seen), 0);

        $display("[TB] two-floor trip up");
        loc_reg = 4'b0001;
        stops.delete();
        strobes.delete();
        apply_stimulus(4'b0100);
        repeat (45) apply_stimulus(4'b0000);
        chk("t2_strobes", strobes.size(), 2);
        if (strobes.size() == 2) begin
            chk("t2_strobe0", int'(strobes[0]), 2);
            chk("t2_strobe1", int'(strobes[1]), 4);
        end
        chk("t2_loc", int'(loc_reg), 4);
        chk("t2_stops", stops.size(), 1);

        $display("[TB] door dwell with re-press");
        loc_reg  = 4'b0010;
        door_cnt = 0;
        apply_stimulus(4'b0010);
        for (int i = 0; i < 100; i++) begin
            apply_stimulus((door_cnt == 9) ? 4'b0010 : 4'b0000);
            if (last_door) door_cnt++;
            else if (door_cnt > 0) break;
        end
        chk("t3_dwell", door_cnt, 26);

        $display("[TB] SCAN up then reverse");
        loc_reg = 4'b0010;
        stops.delete();
        apply_stimulus(4'b1000);
        repeat (2) apply_stimulus(4'b0000);
        apply_stimulus(4'b0001);
        repeat (120) apply_stimulus(4'b0000);
        chk("t4_stops", stops.size(), 2);
        if (stops.size() == 2) begin
            chk("t4_stop0", stops[0], 3);
            chk("t4_stop1", stops[1], 0);
        end
        chk("t4_loc", int'(loc_reg), 1);

        $display("[TB] illegal location values");
        force_en  = 1'b1;
        force_val = 4'b0000;
        apply_stimulus(4'b1111);
        repeat (3) apply_stimulus(4'b0000);
        force_val = 4'b0110;
        repeat (3) apply_stimulus(4'b0000);
        chk("t5_pending", int'(pending), 15);
        chk("t5_fault", int'(fault), 1);
        force_en = 1'b0;
        loc_reg  = 4'b0001;
        stops.delete();
        repeat (200) apply_stimulus(4'b0000);
        chk("t5_stops", stops.size(), 4);
        for (int i = 0; i < stops.size() && i < 4; i++) chk("t5_stop_order", stops[i], i);
        chk("t5_pending_done", int'(pending), 0);

        $display("[TB] top floor with direction up");
        do_reset();
        loc_reg = 4'b1000;
        strobes.delete();
        mu_seen = 1'b0;
        apply_stimulus(4'b0100);
        repeat (40) apply_stimulus(4'b0000);
        chk("t6_no_up", int'(mu_seen), 0);
        chk("t6_strobes", strobes.size(), 1);
        if (strobes.size() == 1) chk("t6_strobe0", int'(strobes[0]), 4);
        chk("t6_loc", int'(loc_reg), 4);

        $display("[TB] random calls with occasional location faults");
        do_reset();
        loc_reg = 4'b0001;
        for (int i = 0; i < 1500; i++) begin
            logic [3:0] c;
            c         = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            force_en  = ($urandom_range(0, 59) == 0);
            force_val = ($urandom_range(0, 1) == 1) ? 4'b0000 : 4'b0101;
            apply_stimulus(c);
        end
        force_en = 1'b0;
        repeat (400) apply_stimulus(4'b0000);
        chk("rand_drained", int'(pending), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
